// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream registered-read FIFO and serialises them 8N1.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN (frame becomes 11 bit-times).
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read_en,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PENULT = BW'(CLKS_PER_BIT - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          r_state;
   logic [BW-1:0]   r_baud;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shreg;
   logic            r_rd_en;
   logic            r_tx;
   logic            r_busy;
   logic            r_tx_done;
`ifdef UART_TX_PARITY_EN
   logic            r_parity;
`endif

   logic            w_start_ok;
   assign w_start_ok = tx_en & ~fifo_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= 3'd0;
         r_shreg   <= 8'h00;
         r_rd_en   <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_state <= S_FETCH;
                  r_rd_en <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_FETCH: begin
               r_rd_en <= 1'b0;
               r_state <= S_LOAD;
            end
            // FIFO read data is registered, so it is valid during LOAD, one cycle after the strobe.
            S_LOAD: begin
               r_shreg <= fifo_data;
`ifdef UART_TX_PARITY_EN
               r_parity <= ^fifo_data;
`endif
               r_baud  <= '0;
               r_tx    <= 1'b0;
               r_state <= S_START;
            end
            S_START: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud    <= '0;
                  r_bit_idx <= 3'd0;
                  r_tx      <= r_shreg[0];
                  r_state   <= S_DATA;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_DATA: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shreg   <= r_shreg >> 1;
                     r_tx      <= r_shreg[1];
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
`endif
            // tx_done is raised one cycle early so the registered pulse lands on the last STOP cycle.
            S_STOP: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud <= '0;
                  if (w_start_ok) begin
                     r_state <= S_FETCH;
                     r_rd_en <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
                  if (r_baud == BAUD_PENULT) r_tx_done <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_rd_en <= 1'b0;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_read_en = r_rd_en;
   assign tx           = r_tx;
   assign busy         = r_busy;
   assign tx_done      = r_tx_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small registered-read FIFO model.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_en;
   logic       fifo_empty;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_read_en;
   logic       tx;
   logic       busy;
   logic       tx_done;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] mem [0:15];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int rd_cnt = 0;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_en        (tx_en),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_read_en (fifo_read_en),
      .tx           (tx),
      .busy         (busy),
      .tx_done      (tx_done)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_read_en === 1'b1) begin
         rd_cnt <= rd_cnt + 1;
         if (rd_ptr != wr_ptr) begin
            fifo_data <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
         end
      end
   end

   // Expected line level c cycles after START entry for byte d.
   function automatic logic exp_bit(input logic [7:0] d, input int c);
      int b;
      b = c / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic push(input logic [7:0] d);
      mem[wr_ptr % 16] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_fetch(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fifo_read_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      tx_en = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (tx !== 1'b1)           begin miscompares++; $display("FAIL reset_tx got %b want 1", tx); end
      vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (tx_done !== 1'b0)      begin miscompares++; $display("FAIL reset_done got %b want 0", tx_done); end
      vectors++; if (fifo_read_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd got %b want 0", fifo_read_en); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_empty();
      int bad_rd, bad_tx, bad_busy;
      bad_rd = 0; bad_tx = 0; bad_busy = 0;
      tx_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fifo_read_en !== 1'b0) bad_rd++;
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
      end
      vectors++; if (bad_rd != 0)   begin miscompares++; $display("FAIL empty_rd got %0d read cycles want 0", bad_rd); end
      vectors++; if (bad_tx != 0)   begin miscompares++; $display("FAIL empty_tx got %0d low cycles want 0", bad_tx); end
      vectors++; if (bad_busy != 0) begin miscompares++; $display("FAIL empty_busy got %0d busy cycles want 0", bad_busy); end
      tx_en = 1'b0;
   endtask

   task automatic test_single_byte();
      bit ok;
      int rd0;
      logic exp_done;
      rd0 = rd_cnt;
      push(8'hA5);
      tx_en = 1'b1;
      wait_fetch(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_fetch got no read want read within 20 cycles"); end
      @(negedge clk);
      vectors++; if (tx !== 1'b1 || fifo_read_en !== 1'b0) begin miscompares++; $display("FAIL single_load got tx=%b rd=%b want tx=1 rd=0", tx, fifo_read_en); end
      for (int c = 0; c < FRAME_CYC; c++) begin
         @(negedge clk);
         exp_done = (c == FRAME_CYC - 1);
         vectors++; if (tx !== exp_bit(8'hA5, c)) begin miscompares++; $display("FAIL single_tx c=%0d got %b want %b", c, tx, exp_bit(8'hA5, c)); end
         vectors++; if (tx_done !== exp_done)     begin miscompares++; $display("FAIL single_done c=%0d got %b want %b", c, tx_done, exp_done); end
         vectors++; if (busy !== 1'b1)            begin miscompares++; $display("FAIL single_busy c=%0d got %b want 1", c, busy); end
      end
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || tx !== 1'b1) begin miscompares++; $display("FAIL single_idle got busy=%b tx=%b want busy=0 tx=1", busy, tx); end
      vectors++; if (rd_cnt - rd0 != 1) begin miscompares++; $display("FAIL single_reads got %0d want 1", rd_cnt - rd0); end
      tx_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      int rd0;
      logic exp_done;
      rd0 = rd_cnt;
      push(8'h00);
      push(8'hFF);
      tx_en = 1'b1;
      wait_fetch(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_fetch got no read want read within 20 cycles"); end
      @(negedge clk);
      for (int c = 0; c < FRAME_CYC; c++) begin
         @(negedge clk);
         exp_done = (c == FRAME_CYC - 1);
         vectors++; if (tx !== exp_bit(8'h00, c)) begin miscompares++; $display("FAIL b2b_tx0 c=%0d got %b want %b", c, tx, exp_bit(8'h00, c)); end
         vectors++; if (tx_done !== exp_done)     begin miscompares++; $display("FAIL b2b_done0 c=%0d got %b want %b", c, tx_done, exp_done); end
      end
      @(negedge clk);
      vectors++; if (fifo_read_en !== 1'b1 || tx !== 1'b1) begin miscompares++; $display("FAIL b2b_gap1 got rd=%b tx=%b want rd=1 tx=1", fifo_read_en, tx); end
      @(negedge clk);
      vectors++; if (fifo_read_en !== 1'b0 || tx !== 1'b1) begin miscompares++; $display("FAIL b2b_gap2 got rd=%b tx=%b want rd=0 tx=1", fifo_read_en, tx); end
      for (int c = 0; c < FRAME_CYC; c++) begin
         @(negedge clk);
         exp_done = (c == FRAME_CYC - 1);
         vectors++; if (tx !== exp_bit(8'hFF, c)) begin miscompares++; $display("FAIL b2b_tx1 c=%0d got %b want %b", c, tx, exp_bit(8'hFF, c)); end
         vectors++; if (tx_done !== exp_done)     begin miscompares++; $display("FAIL b2b_done1 c=%0d got %b want %b", c, tx_done, exp_done); end
      end
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
      vectors++; if (rd_cnt - rd0 != 2) begin miscompares++; $display("FAIL b2b_reads got %0d want 2", rd_cnt - rd0); end
      tx_en = 1'b0;
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      bit ok;
      logic [7:0] bytes [0:1];
      logic       par   [0:1];
      bytes[0] = 8'h07; par[0] = 1'b1;
      bytes[1] = 8'h03; par[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         push(bytes[k]);
         tx_en = 1'b1;
         wait_fetch(ok);
         vectors++; if (!ok) begin miscompares++; $display("FAIL parity_fetch k=%0d got no read want read", k); end
         @(negedge clk);
         for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            vectors++; if (tx !== exp_bit(bytes[k], c)) begin miscompares++; $display("FAIL parity_tx k=%0d c=%0d got %b want %b", k, c, tx, exp_bit(bytes[k], c)); end
            if (c == 9 * CPB + 1) begin
               vectors++; if (tx !== par[k]) begin miscompares++; $display("FAIL parity_bit k=%0d got %b want %b", k, tx, par[k]); end
            end
            if (c == 43) begin
               vectors++; if (tx_done !== 1'b1) begin miscompares++; $display("FAIL parity_done k=%0d got %b want 1", k, tx_done); end
            end
         end
         tx_en = 1'b0;
         @(negedge clk);
      end
   endtask
`endif

   task automatic test_gate();
      bit ok;
      int rd0, bad_rd;
      rd0 = rd_cnt;
      bad_rd = 0;
      push(8'h3C);
      push(8'h11);
      tx_en = 1'b1;
      wait_fetch(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL gate_fetch got no read want read within 20 cycles"); end
      @(negedge clk);
      for (int c = 0; c < FRAME_CYC; c++) begin
         @(negedge clk);
         if (c == 3 * CPB) tx_en = 1'b0;
         vectors++; if (tx !== exp_bit(8'h3C, c)) begin miscompares++; $display("FAIL gate_tx c=%0d got %b want %b", c, tx, exp_bit(8'h3C, c)); end
      end
      vectors++; if (tx_done !== 1'b1) begin miscompares++; $display("FAIL gate_done got %b want 1", tx_done); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fifo_read_en !== 1'b0) bad_rd++;
      end
      vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL gate_idle got busy=%b want 0", busy); end
      vectors++; if (bad_rd != 0)      begin miscompares++; $display("FAIL gate_noread got %0d read cycles want 0", bad_rd); end
      vectors++; if (rd_cnt - rd0 != 1) begin miscompares++; $display("FAIL gate_reads got %0d want 1", rd_cnt - rd0); end
   endtask

   task automatic test_async_reset();
      bit ok;
      int bad_rd;
      bad_rd = 0;
      tx_en = 1'b1;
      wait_fetch(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL arst_fetch got no read want read within 20 cycles"); end
      @(negedge clk);
      for (int c = 0; c <= 10; c++) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      vectors++; if (tx !== 1'b1)           begin miscompares++; $display("FAIL arst_tx got %b want 1", tx); end
      vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL arst_busy got %b want 0", busy); end
      vectors++; if (fifo_read_en !== 1'b0) begin miscompares++; $display("FAIL arst_rd got %b want 0", fifo_read_en); end
      vectors++; if (tx_done !== 1'b0)      begin miscompares++; $display("FAIL arst_done got %b want 0", tx_done); end
      push(8'h5A);
      repeat (3) begin
         @(negedge clk);
         if (fifo_read_en !== 1'b0 || tx !== 1'b1) bad_rd++;
      end
      vectors++; if (bad_rd != 0) begin miscompares++; $display("FAIL arst_hold got %0d bad cycles want 0", bad_rd); end
      rst = 1'b1;
      #1;
      vectors++; if (fifo_read_en !== 1'b0) begin miscompares++; $display("FAIL arst_release got rd=%b want 0", fifo_read_en); end
      @(negedge clk);
      vectors++; if (fifo_read_en !== 1'b1) begin miscompares++; $display("FAIL arst_refetch got rd=%b want 1", fifo_read_en); end
      @(negedge clk);
      for (int c = 0; c < FRAME_CYC; c++) begin
         @(negedge clk);
         vectors++; if (tx !== exp_bit(8'h5A, c)) begin miscompares++; $display("FAIL arst_tx5a c=%0d got %b want %b", c, tx, exp_bit(8'h5A, c)); end
      end
      tx_en = 1'b0;
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_end got busy=%b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_single_byte();
      test_back_to_back();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_gate();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port tx_en, input, 1, which permits starting a new frame when high.
REQ-005 SHALL have port fifo_empty, input, 1, the upstream byte FIFO empty flag.
REQ-006 SHALL have port fifo_data, input, 8, the upstream FIFO registered read data.
REQ-007 SHALL have port fifo_read_en, output, 1, the read strobe to the upstream FIFO.
REQ-008 SHALL have port tx, output, 1, the serial line; idle level high.
REQ-009 SHALL have port busy, output, 1, which is high whenever the state is not IDLE.
REQ-010 SHALL have port tx_done, output, 1, a one-cycle pulse marking the end of a frame.

Function
REQ-011 SHALL implement states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP, all registered, with registered outputs.
REQ-012 IDLE: when tx_en=1 and fifo_empty=0, SHALL go to FETCH; otherwise SHALL stay in IDLE with tx=1.
REQ-013 FETCH: SHALL last exactly 1 cycle with fifo_read_en=1; fifo_read_en SHALL be 0 in every other state.
REQ-014 LOAD: SHALL last 1 cycle; SHALL capture fifo_data into an internal shift register at the closing edge; then go to START.
REQ-015 START: tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA: SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts 0..7 and then exits.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 on the last STOP cycle only.
REQ-018 On leaving STOP, SHALL go to FETCH if tx_en=1 and fifo_empty=0, else to IDLE; back-to-back frames are therefore separated by exactly 2 idle-high cycles (FETCH and LOAD).
REQ-019 tx SHALL be 1 in IDLE, FETCH and LOAD.
REQ-020 A baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 at every bit boundary and state entry; its width SHALL be sufficient for CLKS_PER_BIT without wrap.
REQ-021 A tx_en deassertion mid-frame SHALL NOT abort the frame; it only blocks the next FETCH.
REQ-022 A fifo_empty rise during START, DATA, PARITY or STOP SHALL NOT affect the frame in progress.
REQ-023 A frame SHALL occupy (10 or 11)*CLKS_PER_BIT cycles from START entry to STOP exit.

Reset
REQ-024 When rst=0, SHALL immediately (asynchronously) force state IDLE, tx=1, busy=0, tx_done=0, fifo_read_en=0, counters 0, and shift register 8'h00.
REQ-025 Reset asserted mid-frame SHALL truncate the frame with tx high; no FIFO read SHALL occur until 1 cycle after rst returns to 1.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: DATA SHALL be followed by PARITY, tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then STOP; frame = 11 bit-times.
REQ-027 Macro UART_TX_PARITY_EN undefined: the PARITY state and logic SHALL be absent, DATA SHALL go directly to STOP, and frame = 10 bit-times.

Verification (CLKS_PER_BIT=4)
REQ-028 Reset: rst=0 asynchronously mid-DATA -> tx=1, busy=0, fifo_read_en=0 within the same cycle, no clock edge needed.
REQ-029 Single byte: fifo_empty=0, fifo_data=8'hA5, tx_en=1 -> one fifo_read_en pulse, line 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop), each 4 cycles; tx_done after 40 cycles.
REQ-030 Back-to-back: bytes 8'h00 then 8'hFF available -> exactly 2 high cycles between the first STOP and the second START; exactly 2 read pulses in total.
REQ-031 Empty: fifo_empty=1, tx_en=1 for 100 cycles -> fifo_read_en never 1, tx=1, busy=0.
REQ-032 Gate: tx_en dropped during DATA of byte 8'h3C with the FIFO non-empty -> the frame completes, then IDLE, and no further read occurs.
REQ-033 Parity (macro defined): 8'h07 -> parity bit 1, 44-cycle frame; 8'h03 -> parity bit 0.
